// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth recoding table.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;

  typedef enum logic {IDLE, EMIT} state_e;

  // Window is {b[2k+1], b[2k], b[2k-1]}
  function automatic digit_e booth_digit(input logic [2:0] win);
    digit_e d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational Booth digit encoder: 3-bit window -> one/two/neg select flags.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output logic       one,
  output logic       two,
  output logic       neg
);

  digit_e digit;

  assign digit = booth_digit(win);

  // Split the digit into magnitude select and sign
  always_comb begin
    one = 1'b0;
    two = 1'b0;
    neg = 1'b0;
    case (digit)
      POS1: one = 1'b1;
      POS2: two = 1'b1;
      NEG1: begin one = 1'b1; neg = 1'b1; end
      NEG2: begin two = 1'b1; neg = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_pp_stream_gen.sv
// Sequential radix-4 Booth partial-product generator.
// Accepts one signed operand pair, then streams N/2 pre-shifted 2N-bit
// partial products whose modulo-2^(2N) sum is the signed product.
module booth_pp_stream_gen
  import booth_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 in_a,
  input  logic [N-1:0]                 in_b,
  output logic                         pp_valid,
  input  logic                         pp_ready,
  output logic [2*N-1:0]               pp_data,
  output logic [$clog2(N/2)-1:0]       pp_idx,
  output logic                         pp_last
);

  localparam int NPP = N / 2;
  localparam int IW  = $clog2(NPP);
  localparam int W   = 2 * N;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;

  logic            last;
  logic [N:0]      b_ext;
  logic [2:0]      win;
  logic            sel_one, sel_two, sel_neg;
  logic [W-1:0]    a_ext, mag, sgn, shifted;

  assign pp_valid = (state_q == EMIT);
  assign last     = pp_valid && (idx_q == IW'(NPP - 1));
  assign pp_last  = last;
  assign pp_idx   = idx_q;
  // Combinational from pp_ready so a new pair can ride the final beat
  assign in_ready = (state_q == IDLE) || (last && pp_ready);

  // State, index and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state: load on accept, advance index on each consumed beat
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          idx_d   = '0;
          a_d     = in_a;
          b_d     = in_b;
        end
      end
      EMIT: begin
        if (pp_ready) begin
          if (!last) begin
            idx_d = idx_q + IW'(1);
          end else if (in_valid) begin
            idx_d = '0;
            a_d   = in_a;
            b_d   = in_b;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // b_q[-1] is the implicit zero below the LSB
  assign b_ext = {b_q, 1'b0};
  assign win   = b_ext[{idx_q, 1'b0} +: 3];

  booth_digit_enc u_enc (
    .win (win),
    .one (sel_one),
    .two (sel_two),
    .neg (sel_neg)
  );

  // Select magnitude, negate in full two's complement, shift by 2k, gate when idle
  always_comb begin
    a_ext   = {{N{a_q[N-1]}}, a_q};
    mag     = '0;
    if (sel_two)      mag = {a_ext[W-2:0], 1'b0};
    else if (sel_one) mag = a_ext;
    sgn     = sel_neg ? -mag : mag;
    shifted = sgn << {idx_q, 1'b0};
    pp_data = pp_valid ? shifted : '0;
  end

endmodule

// File: tb/tb_booth_pp_stream_gen.sv
// Scoreboard bench for booth_pp_stream_gen: expected beats are queued when a
// pair is accepted and checked as the DUT presents them.
module tb_booth_pp_stream_gen;

  localparam int N   = 16;
  localparam int W   = 2 * N;
  localparam int NPP = N / 2;
  localparam int IW  = $clog2(NPP);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          pp_valid;
  logic          pp_ready;
  logic [W-1:0]  pp_data;
  logic [IW-1:0] pp_idx;
  logic          pp_last;

  booth_pp_stream_gen #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .pp_valid (pp_valid),
    .pp_ready (pp_ready),
    .pp_data  (pp_data),
    .pp_idx   (pp_idx),
    .pp_last  (pp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    logic         last;
    logic [W-1:0] prod;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        e;
  int           nvec = 0;
  int           nerr = 0;
  logic [W-1:0] acc  = '0;
  logic [W-1:0] seen [NPP];

  // Reference partial product: arithmetic digit value times signed a times 4^k
  function automatic logic [W-1:0] ref_pp(input logic [N-1:0] a, input logic [N-1:0] b, input int k);
    logic [N:0] bx;
    longint     d, p;
    bx = {b, 1'b0};
    d  = longint'(bx[2*k]) + longint'(bx[2*k+1]) - 2 * longint'(bx[2*k+2]);
    p  = d * longint'($signed(a)) * (longint'(1) <<< (2*k));
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[W-1:0];
  endfunction

  task automatic push_pair(input logic [N-1:0] a, input logic [N-1:0] b);
    beat_t t;
    for (int k = 0; k < NPP; k++) begin
      t.data = ref_pp(a, b, k);
      t.idx  = k;
      t.last = (k == NPP - 1);
      t.prod = ref_prod(a, b);
      exp_q.push_back(t);
    end
  endtask

  // Offer a pair and wait (bounded) for the handshake; leaves in_valid high
  task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b);
    int t;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    nvec++;
    if (!in_ready) begin
      nerr++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end else begin
      push_pair(a, b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    pp_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain_timeout: %0d beats outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Beat monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (pp_valid && pp_ready) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_beat: idx=%0d data=%h required no beat", pp_idx, pp_data);
        end else begin
          e = exp_q.pop_front();
          if (pp_data !== e.data) begin
            nerr++;
            $display("FAIL pp_data[%0d]: got %h required %h", e.idx, pp_data, e.data);
          end
          nvec++;
          if (pp_idx !== IW'(e.idx)) begin
            nerr++;
            $display("FAIL pp_idx: got %0d required %0d", pp_idx, e.idx);
          end
          nvec++;
          if (pp_last !== e.last) begin
            nerr++;
            $display("FAIL pp_last[%0d]: got %b required %b", e.idx, pp_last, e.last);
          end
          seen[e.idx] = pp_data;
          acc = acc + pp_data;
          if (e.last) begin
            nvec++;
            if (acc !== e.prod) begin
              nerr++;
              $display("FAIL pp_sum: got %h required %h", acc, e.prod);
            end
            acc = '0;
          end
        end
      end else if (!pp_valid) begin
        nvec++;
        if (pp_data !== '0 || pp_last !== 1'b0) begin
          nerr++;
          $display("FAIL idle_outputs: data=%h last=%b required 0/0", pp_data, pp_last);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    pp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (pp_valid !== 1'b0 || pp_data !== '0 || pp_idx !== '0 || pp_last !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs: valid=%b data=%h idx=%0d last=%b required 0/0/0/0",
               pp_valid, pp_data, pp_idx, pp_last);
    end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    @(posedge clk);
    #1;
    pp_ready = 1'b1;
    send_pair(16'd3, 16'd5);
    in_valid = 1'b0;
    wait_drain();
    nvec++;
    if (seen[0] !== 32'h0000_0003 || seen[1] !== 32'h0000_000C || seen[2] !== '0 || seen[7] !== '0) begin
      nerr++;
      $display("FAIL pp_3x5: got %h %h %h %h required 00000003 0000000c 0 0",
               seen[0], seen[1], seen[2], seen[7]);
    end
    send_pair(16'hFFFF, 16'hFFFF);
    in_valid = 1'b0;
    wait_drain();
    nvec++;
    if (seen[0] !== 32'h0000_0001 || seen[1] !== '0 || seen[7] !== '0) begin
      nerr++;
      $display("FAIL pp_m1xm1: got %h %h %h required 00000001 0 0", seen[0], seen[1], seen[7]);
    end
    send_pair(16'h7FFF, 16'h8000);
    in_valid = 1'b0;
    wait_drain();
    nvec++;
    if (seen[7] !== 32'hC000_8000 || seen[0] !== '0 || seen[6] !== '0) begin
      nerr++;
      $display("FAIL pp_max_min: got pp7=%h pp0=%h pp6=%h required c0008000 0 0",
               seen[7], seen[0], seen[6]);
    end
  endtask

  task automatic test_stall();
    int t;
    logic [W-1:0]  d0;
    logic [IW-1:0] i0;
    logic          l0;
    pp_ready = 1'b1;
    send_pair(16'h1234, 16'h5A5A);
    in_valid = 1'b1;
    in_a     = 16'h0F0F;
    in_b     = 16'hAAAA;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(pp_valid && pp_idx == IW'(1)) && t < 50);
    @(posedge clk);
    #1;
    pp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        d0 = pp_data;
        i0 = pp_idx;
        l0 = pp_last;
        nvec++;
        if (i0 !== IW'(2)) begin
          nerr++;
          $display("FAIL stall_idx: got %0d required 2", i0);
        end
      end
      nvec++;
      if (pp_data !== d0 || pp_idx !== i0 || pp_last !== l0 || in_ready !== 1'b0 || pp_valid !== 1'b1) begin
        nerr++;
        $display("FAIL stall_hold: data=%h idx=%0d last=%b in_ready=%b required %h/%0d/%b/0",
                 pp_data, pp_idx, pp_last, in_ready, d0, i0, l0);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    pp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (pp_idx !== IW'(3)) begin
      nerr++;
      $display("FAIL stall_resume: got %0d required 3", pp_idx);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    pp_ready = 1'b1;
    send_pair(16'd3, 16'd5);
    fork
      begin
        send_pair(16'hFFFF, 16'hFFFF);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 2 * NPP; c++) begin
          @(negedge clk);
          nvec++;
          if (pp_valid !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_bubble: beat %0d pp_valid=%b required 1", c, pp_valid);
          end
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_midburst();
    int t;
    pp_ready = 1'b1;
    send_pair(16'h00A5, 16'hC3C3);
    in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(pp_valid && pp_idx == IW'(4)) && t < 50);
    #1;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (pp_valid !== 1'b0 || pp_data !== '0 || pp_idx !== '0 || pp_last !== 1'b0) begin
      nerr++;
      $display("FAIL midburst_reset: valid=%b data=%h idx=%0d last=%b required 0/0/0/0",
               pp_valid, pp_data, pp_idx, pp_last);
    end
    exp_q.delete();
    acc = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL post_reset_ready: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    send_pair(16'hFFF9, 16'd12345);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          int g;
          g = $urandom_range(0, 2);
          if (g != 0) begin
            in_valid = 1'b0;
            repeat (g) begin
              @(posedge clk);
              #1;
            end
          end
          send_pair(N'($urandom), N'($urandom));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          pp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
